// File: rtl/machine_mode_types_pkg.sv
// Shared machine-mode trap types: sequencer states, mcause codes, helpers.
// Ports: none (package).
// Used by prv_trap_prio and prv_trap_sequencer.
package machine_mode_types_pkg;

  localparam int unsigned CODE_W = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    COMMIT = 2'd2,
    RET    = 2'd3
  } trap_state_t;

  typedef enum logic [CODE_W-1:0] {
    EX_MAL_INSN   = 31'd0,
    EX_FAULT_INSN = 31'd1,
    EX_ILLEGAL    = 31'd2,
    EX_BREAKPOINT = 31'd3,
    EX_MAL_L      = 31'd4,
    EX_FAULT_L    = 31'd5,
    EX_MAL_S      = 31'd6,
    EX_FAULT_S    = 31'd7,
    EX_ENV_M      = 31'd11
  } ex_code_t;

  typedef enum logic [CODE_W-1:0] {
    INT_SOFT  = 31'd3,
    INT_TIMER = 31'd7,
    INT_EXT   = 31'd11
  } int_code_t;

  // mepc holds a word-aligned address; the low two bits never reach the CSR.
  function automatic logic [31:0] align_epc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/prv_trap_prio.sv
// Combinational trap priority encoder: exception flags and enabled M-mode
// interrupts -> {valid, is_int, 31-bit cause code, badaddr_valid}.
// Ports: raw exception/interrupt flags and enables in; selected trap out. No state.
module prv_trap_prio
  import machine_mode_types_pkg::*;
#(
  parameter int unsigned RMGMT_W    = 2,
  parameter int unsigned RMGMT_BASE = 24
) (
  input  logic               fault_insn_i,
  input  logic               mal_insn_i,
  input  logic               illegal_insn_i,
  input  logic               breakpoint_i,
  input  logic               env_m_i,
  input  logic               mal_l_i,
  input  logic               fault_l_i,
  input  logic               mal_s_i,
  input  logic               fault_s_i,
  input  logic               ex_rmgmt_i,
  input  logic [RMGMT_W-1:0] ex_rmgmt_cause_i,
  input  logic               ext_int_i,
  input  logic               soft_int_i,
  input  logic               timer_int_i,
  input  logic [2:0]         mie_en_i,
  input  logic               mstatus_mie_i,
  output logic               vld_o,
  output logic               is_int_o,
  output logic [CODE_W-1:0]  code_o,
  output logic               badaddr_vld_o
);

  // Interrupt is only takeable when individually enabled and globally enabled.
  // Bit order follows mie: {meie, mtie, msie}.
  logic [2:0] int_pend;
  assign int_pend = {ext_int_i, timer_int_i, soft_int_i} & mie_en_i & {3{mstatus_mie_i}};

  always_comb begin
    vld_o         = 1'b1;
    is_int_o      = 1'b0;
    code_o        = '0;
    badaddr_vld_o = 1'b0;
    // Exceptions always beat interrupts.
    if (fault_insn_i) begin
      code_o        = EX_FAULT_INSN;
      badaddr_vld_o = 1'b1;
    end else if (mal_insn_i) begin
      code_o        = EX_MAL_INSN;
      badaddr_vld_o = 1'b1;
    end else if (illegal_insn_i) begin
      code_o = EX_ILLEGAL;
    end else if (breakpoint_i) begin
      code_o = EX_BREAKPOINT;
    end else if (env_m_i) begin
      code_o = EX_ENV_M;
    end else if (mal_l_i) begin
      code_o        = EX_MAL_L;
      badaddr_vld_o = 1'b1;
    end else if (fault_l_i) begin
      code_o        = EX_FAULT_L;
      badaddr_vld_o = 1'b1;
    end else if (mal_s_i) begin
      code_o        = EX_MAL_S;
      badaddr_vld_o = 1'b1;
    end else if (fault_s_i) begin
      code_o        = EX_FAULT_S;
      badaddr_vld_o = 1'b1;
    end else if (ex_rmgmt_i) begin
      code_o = CODE_W'(RMGMT_BASE) + CODE_W'(ex_rmgmt_cause_i);
    end else if (int_pend[2]) begin
      is_int_o = 1'b1;
      code_o   = INT_EXT;
    end else if (int_pend[0]) begin
      is_int_o = 1'b1;
      code_o   = INT_SOFT;
    end else if (int_pend[1]) begin
      is_int_o = 1'b1;
      code_o   = INT_TIMER;
    end else begin
      vld_o = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Trap/return sequencer for the privilege block: IDLE -> FLUSH (intr until
// pipe_clear) -> COMMIT (one-cycle CSR strobes) -> IDLE; mret via a one-cycle RET.
// Ports: exception/interrupt flags, CSR state, epc/badaddr, ret, pipe_clear in;
// intr, CSR write strobes and next values out. mip mirror runs independently.
module prv_trap_sequencer
  import machine_mode_types_pkg::*;
#(
  parameter int unsigned RMGMT_W    = 2,
  parameter int unsigned RMGMT_BASE = 24
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               fault_insn,
  input  logic               mal_insn,
  input  logic               illegal_insn,
  input  logic               fault_l,
  input  logic               mal_l,
  input  logic               fault_s,
  input  logic               mal_s,
  input  logic               breakpoint,
  input  logic               env_m,
  input  logic               ex_rmgmt,
  input  logic [RMGMT_W-1:0] ex_rmgmt_cause,
  input  logic               ext_int,
  input  logic               soft_int,
  input  logic               timer_int,
  input  logic [2:0]         mie_en,
  input  logic               mstatus_mie,
  input  logic               mstatus_mpie,
  input  logic [31:0]        epc,
  input  logic [31:0]        badaddr,
  input  logic               ret,
  input  logic               pipe_clear,
  output logic               intr,
  output logic               mcause_rup,
  output logic               mepc_rup,
  output logic               mbadaddr_rup,
  output logic               mstatus_rup,
  output logic               mip_rup,
  output logic [31:0]        mcause_next,
  output logic [31:0]        mepc_next,
  output logic [31:0]        mbadaddr_next,
  output logic               mstatus_mie_next,
  output logic               mstatus_mpie_next,
  output logic [2:0]         mip_next
);

  logic              trap_vld;
  logic              trap_is_int;
  logic [CODE_W-1:0] trap_code;
  logic              trap_bad_vld;

  prv_trap_prio #(
    .RMGMT_W    (RMGMT_W),
    .RMGMT_BASE (RMGMT_BASE)
  ) u_prio (
    .fault_insn_i     (fault_insn),
    .mal_insn_i       (mal_insn),
    .illegal_insn_i   (illegal_insn),
    .breakpoint_i     (breakpoint),
    .env_m_i          (env_m),
    .mal_l_i          (mal_l),
    .fault_l_i        (fault_l),
    .mal_s_i          (mal_s),
    .fault_s_i        (fault_s),
    .ex_rmgmt_i       (ex_rmgmt),
    .ex_rmgmt_cause_i (ex_rmgmt_cause),
    .ext_int_i        (ext_int),
    .soft_int_i       (soft_int),
    .timer_int_i      (timer_int),
    .mie_en_i         (mie_en),
    .mstatus_mie_i    (mstatus_mie),
    .vld_o            (trap_vld),
    .is_int_o         (trap_is_int),
    .code_o           (trap_code),
    .badaddr_vld_o    (trap_bad_vld)
  );

  trap_state_t state_q, state_d;
  logic        latch_en;

  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] badaddr_q;
  logic        bad_vld_q;
  logic [2:0]  mip_q;
  logic        mip_rup_q;

  // Next state. Only IDLE samples events; anything arriving mid-sequence is
  // dropped and will be re-raised by the pipeline.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trap_vld) begin
          state_d  = FLUSH;
          latch_en = 1'b1;
        end else if (ret) begin
          state_d = RET;
        end
      end
      FLUSH:   if (pipe_clear) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so intr and strobes are glitch-free
  // and drop immediately on async reset.
  always_comb begin
    intr              = 1'b0;
    mcause_rup        = 1'b0;
    mepc_rup          = 1'b0;
    mbadaddr_rup      = 1'b0;
    mstatus_rup       = 1'b0;
    mstatus_mie_next  = 1'b0;
    mstatus_mpie_next = 1'b0;
    unique case (state_q)
      FLUSH: intr = 1'b1;
      COMMIT: begin
        mcause_rup        = 1'b1;
        mepc_rup          = 1'b1;
        mstatus_rup       = 1'b1;
        mbadaddr_rup      = bad_vld_q;
        // Push the interrupt-enable stack: mpie <- mie, mie <- 0.
        mstatus_mpie_next = mstatus_mie;
        mstatus_mie_next  = 1'b0;
      end
      RET: begin
        // Pop the stack: mie <- mpie, mpie <- 1.
        mstatus_rup       = 1'b1;
        mstatus_mie_next  = mstatus_mpie;
        mstatus_mpie_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      epc_q     <= '0;
      badaddr_q <= '0;
      bad_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        cause_q   <= {trap_is_int, trap_code};
        epc_q     <= align_epc(epc);
        badaddr_q <= badaddr;
        bad_vld_q <= trap_bad_vld;
      end
    end
  end

  // mip mirror: registered copy of the raw lines, strobe on any change.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mip_q     <= '0;
      mip_rup_q <= 1'b0;
    end else begin
      mip_q     <= {ext_int, timer_int, soft_int};
      mip_rup_q <= ({ext_int, timer_int, soft_int} != mip_q);
    end
  end

  assign mcause_next   = cause_q;
  assign mepc_next     = epc_q;
  assign mbadaddr_next = badaddr_q;
  assign mip_next      = mip_q;
  assign mip_rup       = mip_rup_q;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
module tb_prv_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic        breakpoint, env_m, ex_rmgmt;
  logic [1:0]  ex_rmgmt_cause;
  logic        ext_int, soft_int, timer_int;
  logic [2:0]  mie_en;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] epc, badaddr;
  logic        ret, pipe_clear;
  logic        intr, mcause_rup, mepc_rup, mbadaddr_rup, mstatus_rup, mip_rup;
  logic [31:0] mcause_next, mepc_next, mbadaddr_next;
  logic        mstatus_mie_next, mstatus_mpie_next;
  logic [2:0]  mip_next;

  always #5 CLK = ~CLK;

  prv_trap_sequencer dut (
    .CLK(CLK), .nRST(nRST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env_m(env_m), .ex_rmgmt(ex_rmgmt),
    .ex_rmgmt_cause(ex_rmgmt_cause),
    .ext_int(ext_int), .soft_int(soft_int), .timer_int(timer_int),
    .mie_en(mie_en), .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .epc(epc), .badaddr(badaddr), .ret(ret), .pipe_clear(pipe_clear),
    .intr(intr), .mcause_rup(mcause_rup), .mepc_rup(mepc_rup),
    .mbadaddr_rup(mbadaddr_rup), .mstatus_rup(mstatus_rup), .mip_rup(mip_rup),
    .mcause_next(mcause_next), .mepc_next(mepc_next), .mbadaddr_next(mbadaddr_next),
    .mstatus_mie_next(mstatus_mie_next), .mstatus_mpie_next(mstatus_mpie_next),
    .mip_next(mip_next)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ex bit order: {fault_insn, mal_insn, illegal_insn, breakpoint, env_m,
  //                mal_l, fault_l, mal_s, fault_s, ex_rmgmt}
  task automatic set_ex(input logic [9:0] ex, input logic [1:0] rc);
    {fault_insn, mal_insn, illegal_insn, breakpoint, env_m,
     mal_l, fault_l, mal_s, fault_s, ex_rmgmt} = ex;
    ex_rmgmt_cause = rc;
  endtask

  typedef struct {
    logic [9:0]  ex;
    logic [1:0]  rc;
    logic [2:0]  ints;      // {ext, timer, soft}
    logic [2:0]  mie_en;
    logic        mie;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        exp_trap;
    logic [31:0] exp_cause;
    logic        exp_brup;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{10'b0010000000, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'd2,         1'b0};
    vecs[1]  = '{10'b0000010010, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_0400, 32'h0000_1003, 1'b1, 32'd4,         1'b1};
    vecs[2]  = '{10'b0000000000, 2'd0, 3'b110, 3'b111, 1'b1, 32'h0000_0800, 32'h0,         1'b1, 32'h8000_000B, 1'b0};
    vecs[3]  = '{10'b0000000000, 2'd0, 3'b110, 3'b000, 1'b1, 32'h0000_0800, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[4]  = '{10'b1111111111, 2'd3, 3'b111, 3'b111, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 32'd1,         1'b1};
    vecs[5]  = '{10'b0110000000, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_1004, 32'h0000_1005, 1'b1, 32'd0,         1'b1};
    vecs[6]  = '{10'b0001100000, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'd3,         1'b0};
    vecs[7]  = '{10'b0000110000, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'd11,        1'b0};
    vecs[8]  = '{10'b0000001100, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_1010, 32'h0000_2000, 1'b1, 32'd5,         1'b1};
    vecs[9]  = '{10'b0000000110, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_1014, 32'h0000_3002, 1'b1, 32'd6,         1'b1};
    vecs[10] = '{10'b0000000010, 2'd0, 3'b000, 3'b000, 1'b0, 32'h0000_1018, 32'h0000_4004, 1'b1, 32'd7,         1'b1};
    vecs[11] = '{10'b0000000001, 2'd2, 3'b000, 3'b000, 1'b0, 32'h0000_101C, 32'h0,         1'b1, 32'd26,        1'b0};
    vecs[12] = '{10'b0010000000, 2'd0, 3'b100, 3'b111, 1'b1, 32'h0000_1020, 32'h0,         1'b1, 32'd2,         1'b0};
    vecs[13] = '{10'b0000000000, 2'd0, 3'b011, 3'b111, 1'b1, 32'h0000_1024, 32'h0,         1'b1, 32'h8000_0003, 1'b0};
    vecs[14] = '{10'b0000000000, 2'd0, 3'b010, 3'b010, 1'b0, 32'h0000_1028, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[15] = '{10'b0000000000, 2'd0, 3'b010, 3'b010, 1'b1, 32'h0000_1028, 32'h0,         1'b1, 32'h8000_0007, 1'b0};
    vecs[16] = '{10'b0000000000, 2'd0, 3'b101, 3'b011, 1'b1, 32'h0000_102C, 32'h0,         1'b1, 32'h8000_0003, 1'b0};
    vecs[17] = '{10'b0000000000, 2'd1, 3'b000, 3'b000, 1'b0, 32'h0000_0203, 32'h0,         1'b0, 32'h0,         1'b0};
  end

  initial begin
    int  nint;
    logic done;
    nRST = 1'b0;
    set_ex(10'b0, 2'd0);
    {ext_int, timer_int, soft_int} = 3'b000;
    mie_en = 3'b000; mstatus_mie = 1'b0; mstatus_mpie = 1'b0;
    epc = '0; badaddr = '0; ret = 1'b0; pipe_clear = 1'b0;

    // Reset state
    #3;
    chk1 ("rst_intr",        intr,          1'b0);
    chk1 ("rst_mcause_rup",  mcause_rup,    1'b0);
    chk1 ("rst_mstatus_rup", mstatus_rup,   1'b0);
    chk1 ("rst_mip_rup",     mip_rup,       1'b0);
    chk32("rst_mcause",      mcause_next,   32'h0);
    chk32("rst_mepc",        mepc_next,     32'h0);
    chk32("rst_mbadaddr",    mbadaddr_next, 32'h0);
    chk32("rst_mip",         32'(mip_next), 32'h0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);

    // Table-driven single traps, pipe_clear raised in the first FLUSH cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      set_ex(vecs[i].ex, vecs[i].rc);
      {ext_int, timer_int, soft_int} = vecs[i].ints;
      mie_en = vecs[i].mie_en; mstatus_mie = vecs[i].mie;
      epc = vecs[i].epc; badaddr = vecs[i].bad;
      @(negedge CLK);
      set_ex(10'b0, 2'd0);
      {ext_int, timer_int, soft_int} = 3'b000;
      pipe_clear = 1'b1;
      chk1($sformatf("v%0d_intr", i), intr, vecs[i].exp_trap);
      @(negedge CLK);
      pipe_clear = 1'b0;
      chk1($sformatf("v%0d_mcause_rup", i), mcause_rup, vecs[i].exp_trap);
      if (vecs[i].exp_trap) begin
        chk32($sformatf("v%0d_mcause", i), mcause_next, vecs[i].exp_cause);
        chk32($sformatf("v%0d_mepc", i), mepc_next, vecs[i].epc & 32'hFFFF_FFFC);
        chk1 ($sformatf("v%0d_mepc_rup", i), mepc_rup, 1'b1);
        chk1 ($sformatf("v%0d_mbad_rup", i), mbadaddr_rup, vecs[i].exp_brup);
        chk1 ($sformatf("v%0d_mpie_next", i), mstatus_mpie_next, vecs[i].mie);
        chk1 ($sformatf("v%0d_mie_next", i), mstatus_mie_next, 1'b0);
        chk1 ($sformatf("v%0d_intr_commit", i), intr, 1'b0);
        if (vecs[i].exp_brup)
          chk32($sformatf("v%0d_mbadaddr", i), mbadaddr_next, vecs[i].bad);
      end
      @(negedge CLK);
      chk1($sformatf("v%0d_idle_mstatus_rup", i), mstatus_rup, 1'b0);
    end
    mstatus_mie = 1'b0; mie_en = 3'b000;

    // Long flush: pipe_clear only in the third FLUSH cycle
    @(negedge CLK);
    set_ex(10'b0010000000, 2'd0); epc = 32'h200; badaddr = 32'h55;
    nint = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK);
      if (k == 0) set_ex(10'b0, 2'd0);
      if (mcause_rup) done = 1'b1;
      else begin
        if (intr) nint++;
        pipe_clear = (nint == 3);
      end
    end
    chk1 ("long_commit_seen", done, 1'b1);
    chk32("long_intr_cycles", nint, 32'd3);
    chk32("long_mcause", mcause_next, 32'd2);
    chk32("long_mepc", mepc_next, 32'h200);
    chk1 ("long_mbad_rup", mbadaddr_rup, 1'b0);
    pipe_clear = 1'b0;
    @(negedge CLK);
    chk1("long_back_idle_intr", intr, 1'b0);

    // pipe_clear already high on FLUSH entry: FLUSH is one cycle
    set_ex(10'b0000001000, 2'd0); epc = 32'h40; badaddr = 32'hABC; pipe_clear = 1'b1;
    @(negedge CLK);
    set_ex(10'b0, 2'd0);
    chk1("pc_early_intr", intr, 1'b1);
    @(negedge CLK);
    chk1 ("pc_early_commit", mcause_rup, 1'b1);
    chk1 ("pc_early_intr_off", intr, 1'b0);
    chk32("pc_early_mcause", mcause_next, 32'd5);
    chk32("pc_early_mbadaddr", mbadaddr_next, 32'hABC);
    pipe_clear = 1'b0;
    @(negedge CLK);

    // mret with mpie=1: one-cycle RET
    ret = 1'b1; mstatus_mpie = 1'b1; mstatus_mie = 1'b0;
    @(negedge CLK);
    ret = 1'b0;
    chk1("ret_mstatus_rup", mstatus_rup, 1'b1);
    chk1("ret_mie_next", mstatus_mie_next, 1'b1);
    chk1("ret_mpie_next", mstatus_mpie_next, 1'b1);
    chk1("ret_no_mcause_rup", mcause_rup, 1'b0);
    chk1("ret_no_intr", intr, 1'b0);
    @(negedge CLK);
    chk1("ret_one_cycle", mstatus_rup, 1'b0);
    mstatus_mpie = 1'b0;

    // ret and ecall together: trap wins, ret dropped
    set_ex(10'b0000100000, 2'd0); ret = 1'b1; epc = 32'h300;
    @(negedge CLK);
    set_ex(10'b0, 2'd0); ret = 1'b0;
    chk1("rete_intr", intr, 1'b1);
    chk1("rete_not_ret", mstatus_rup, 1'b0);
    pipe_clear = 1'b1;
    @(negedge CLK);
    pipe_clear = 1'b0;
    chk1 ("rete_commit", mcause_rup, 1'b1);
    chk32("rete_mcause", mcause_next, 32'd11);
    @(negedge CLK);
    chk1("rete_no_ret_after", mstatus_rup, 1'b0);

    // mip mirror
    timer_int = 1'b1;
    #1 chk1("mip_rup_before_edge", mip_rup, 1'b0);
    @(negedge CLK);
    chk1 ("mip_rup_rise", mip_rup, 1'b1);
    chk32("mip_next_rise", 32'(mip_next), 32'h2);
    @(negedge CLK);
    chk1 ("mip_rup_steady", mip_rup, 1'b0);
    chk32("mip_next_steady", 32'(mip_next), 32'h2);
    timer_int = 1'b0;
    @(negedge CLK);
    chk1 ("mip_rup_fall", mip_rup, 1'b1);
    chk32("mip_next_fall", 32'(mip_next), 32'h0);
    @(negedge CLK);

    // Async reset in the middle of FLUSH
    set_ex(10'b1000000000, 2'd0); epc = 32'h900; badaddr = 32'h904;
    @(negedge CLK);
    set_ex(10'b0, 2'd0);
    chk1("arst_in_flush", intr, 1'b1);
    pipe_clear = 1'b1;
    #2 nRST = 1'b0;
    #1 chk1("arst_intr_drop", intr, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk1($sformatf("arst_no_rup_%0d", k),
           mcause_rup | mepc_rup | mbadaddr_rup | mstatus_rup, 1'b0);
      chk1($sformatf("arst_no_intr_%0d", k), intr, 1'b0);
    end
    chk32("arst_mcause_clear", mcause_next, 32'h0);
    chk32("arst_mepc_clear", mepc_next, 32'h0);
    pipe_clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
